// File: rtl/sys_cfg_pkg.sv
// Bank layout helpers shared by the config register bank and its register cells.
package sys_cfg_pkg;

  // Widest register the lane-mask helper can serve (128-bit data).
  localparam int unsigned MAX_BYTES = 16;
  localparam int unsigned MAX_WIDTH = MAX_BYTES * 8;

  // Reads of unmapped words return this bit replicated across the data word.
  localparam logic UNMAPPED_BIT = 1'b0;

  // Word index of the W1C interrupt status register.
  function automatic int unsigned irq_stat_idx(input int unsigned rw_num, input int unsigned ro_num);
    return rw_num + ro_num;
  endfunction

  // Word index of the interrupt enable register.
  function automatic int unsigned irq_en_idx(input int unsigned rw_num, input int unsigned ro_num);
    return rw_num + ro_num + 1;
  endfunction

  // Expand byte enables into a bit mask, 8 bits per lane.
  function automatic logic [MAX_WIDTH-1:0] lane_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < int'(MAX_BYTES); b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cfg_reg_be.sv
// Single byte-writable register with a one-cycle update strobe.
module cfg_reg_be
  import sys_cfg_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BYTE_NUM   = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [BYTE_NUM-1:0]   be,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  wr_pulse
);

  logic [DATA_WIDTH-1:0] mask_c;

  assign mask_c = DATA_WIDTH'(lane_mask(MAX_BYTES'(be)));

  // Merge enabled byte lanes; strobe is aligned with the new contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q        <= RST_VALUE;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      if (wr_en) begin
        q <= (q & ~mask_c) | (din & mask_c);
      end
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised RW/RO/IRQ register bank behind a BRAM controller port.
module cfg_reg_bank
  import sys_cfg_pkg::*;
#(
  parameter int unsigned                   ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]         BASE_ADDR  = ADDR_WIDTH'(32'h0001_0000),
  parameter int unsigned                   DATA_WIDTH = 32,
  parameter int unsigned                   BYTE_NUM   = DATA_WIDTH / 8,
  parameter int unsigned                   DEC_BITS   = 16,
  parameter int unsigned                   RW_NUM     = 8,
  parameter int unsigned                   RO_NUM     = 4,
  parameter int unsigned                   IRQ_NUM    = 8,
  parameter logic [RW_NUM*DATA_WIDTH-1:0]  RST_VAL    = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bram_en,
  input  logic [BYTE_NUM-1:0]          bram_we,
  input  logic [ADDR_WIDTH-1:0]        bram_addr,
  input  logic [DATA_WIDTH-1:0]        bram_din,
  output logic [DATA_WIDTH-1:0]        bram_dout,
  output logic [RW_NUM*DATA_WIDTH-1:0] rw_reg,
  output logic [RW_NUM-1:0]            rw_wr_pulse,
  input  logic [RO_NUM*DATA_WIDTH-1:0] ro_reg,
  input  logic [IRQ_NUM-1:0]           irq_src,
  output logic                         irq
);

  localparam int unsigned LSB      = $clog2(BYTE_NUM);
  localparam int unsigned IDX_W    = DEC_BITS - LSB;
  localparam int unsigned TAG_W    = ADDR_WIDTH - DEC_BITS;
  localparam int unsigned STAT_IDX = irq_stat_idx(RW_NUM, RO_NUM);
  localparam int unsigned EN_IDX   = irq_en_idx(RW_NUM, RO_NUM);
  localparam logic [TAG_W-1:0]      BASE_TAG = BASE_ADDR[ADDR_WIDTH-1:DEC_BITS];
  localparam logic [DATA_WIDTH-1:0] IRQ_MASK = DATA_WIDTH'({IRQ_NUM{1'b1}});

  logic                  hit_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] rd_val_c;
  logic [DATA_WIDTH-1:0] clr_c;

  logic                  wr_vld;
  logic [IDX_W-1:0]      wr_idx;
  logic [BYTE_NUM-1:0]   wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] irq_stat;
  logic [DATA_WIDTH-1:0] irq_en;
  logic                  unused_irq_en_pulse;

  // Exact tag match on all address bits above the window keeps the map alias-free.
  assign hit_c = bram_en && (bram_addr[ADDR_WIDTH-1:DEC_BITS] == BASE_TAG);
  assign idx_c = bram_addr[DEC_BITS-1:LSB];
  assign wr_c  = hit_c && (|bram_we);
  assign rd_c  = hit_c && !(|bram_we);

  if (LSB > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bram_addr[LSB-1:0];
  end

  // Write pipe stage: capture the access, retire it on the following edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_vld  <= 1'b0;
      wr_idx  <= '0;
      wr_be   <= '0;
      wr_data <= '0;
    end else begin
      wr_vld <= wr_c;
      if (wr_c) begin
        wr_idx  <= idx_c;
        wr_be   <= bram_we;
        wr_data <= bram_din;
      end
    end
  end

  for (genvar gi = 0; gi < int'(RW_NUM); gi++) begin : g_rw
    cfg_reg_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_NUM   (BYTE_NUM),
      .RST_VALUE  (RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH])
    ) u_rw (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_vld && (wr_idx == IDX_W'(gi))),
      .be       (wr_be),
      .din      (wr_data),
      .q        (rw_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
      .wr_pulse (rw_wr_pulse[gi])
    );
  end

  // Enable bits beyond the implemented sources are never stored.
  cfg_reg_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_NUM   (BYTE_NUM),
    .RST_VALUE  ('0)
  ) u_irq_en (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_vld && (wr_idx == IDX_W'(EN_IDX))),
    .be       (wr_be),
    .din      (wr_data & IRQ_MASK),
    .q        (irq_en),
    .wr_pulse (unused_irq_en_pulse)
  );

  assign clr_c = (wr_vld && (wr_idx == IDX_W'(STAT_IDX)))
               ? (wr_data & DATA_WIDTH'(lane_mask(MAX_BYTES'(wr_be))))
               : '0;

  // Sticky status: a live source outranks a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_stat <= '0;
    end else begin
      irq_stat <= ((irq_stat & ~clr_c) | DATA_WIDTH'(irq_src)) & IRQ_MASK;
    end
  end

  // Registered interrupt level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_stat & irq_en);
    end
  end

  // Read mux over the current register contents; status inputs sampled live.
  always_comb begin
    rd_val_c = {DATA_WIDTH{UNMAPPED_BIT}};
    for (int i = 0; i < int'(RW_NUM); i++) begin
      if (idx_c == IDX_W'(i)) rd_val_c = rw_reg[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < int'(RO_NUM); i++) begin
      if (idx_c == IDX_W'(RW_NUM + i)) rd_val_c = ro_reg[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (idx_c == IDX_W'(STAT_IDX)) rd_val_c = irq_stat;
    if (idx_c == IDX_W'(EN_IDX))   rd_val_c = irq_en;
  end

  // Read data register holds between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bram_dout <= '0;
    end else if (rd_c) begin
      bram_dout <= rd_val_c;
    end
  end

endmodule
